// File: rtl/branch_predictor_pkg.sv
// Shared constants for the IF-stage branch predictor: branch type codes,
// default table geometry and 2-bit counter initial values.
package branch_predictor_pkg;

    localparam int BP_INDEX_W = 6;

    typedef enum logic [2:0] {
        BR_NOBRANCH = 3'd0,
        BR_BEQ      = 3'd1,
        BR_BNE      = 3'd2,
        BR_BLT      = 3'd3,
        BR_BGE      = 3'd4,
        BR_BLTU     = 3'd5,
        BR_BGEU     = 3'd6
    } br_type_e;

    localparam logic [2:0] NOBRANCH  = 3'd0;
    localparam logic [1:0] BHT_INIT  = 2'b01;
    localparam logic [1:0] BHT_ALLOC = 2'b10;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Combinational next-state for a 2-bit saturating counter.
import branch_predictor_pkg::*;

module bp_sat_counter2 (
    input  logic [1:0] cnt_i,
    input  logic       inc_i,
    output logic [1:0] cnt_o
);

    // Saturating step: clamp at 2'b11 going up and 2'b00 going down
    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != 2'b11) begin
                cnt_o = cnt_i + 2'b01;
            end else begin
                cnt_o = cnt_i;
            end
        end else begin
            if (cnt_i != 2'b00) begin
                cnt_o = cnt_i - 2'b01;
            end else begin
                cnt_o = cnt_i;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit BHT per entry: same-cycle prediction for the
// fetch PC, EX-stage misprediction detection, table training and statistics.
import branch_predictor_pkg::*;

module branch_predictor #(
    parameter int INDEX_W = BP_INDEX_W,
    parameter int TAG_W   = 30 - INDEX_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic [2:0]  ex_br_type_i,
    input  logic        ex_br_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] stat_total_o,
    output logic [31:0] stat_miss_o
);

    localparam int ENTRIES = 1 << INDEX_W;

    logic              valid_q  [ENTRIES];
    logic [1:0]        bht_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [31:0]       stat_total_q, stat_total_d;
    logic [31:0]       stat_miss_q, stat_miss_d;

    logic [INDEX_W-1:0] if_idx_s;
    logic [TAG_W-1:0]   if_tag_s;
    logic               if_hit_s;
    logic [INDEX_W-1:0] ex_idx_s;
    logic [TAG_W-1:0]   ex_tag_s;
    logic               ex_hit_s;
    logic               is_br_s;
    logic               upd_hit_s;
    logic               alloc_s;
    logic               wr_target_s;
    logic [1:0]         bht_next_s;

    assign if_idx_s = if_pc_i[INDEX_W+1:2];
    assign if_tag_s = if_pc_i[31:INDEX_W+2];
    assign ex_idx_s = ex_pc_i[INDEX_W+1:2];
    assign ex_tag_s = ex_pc_i[31:INDEX_W+2];

    // Fetch-side lookup; sees table contents from before any same-cycle update
    always_comb begin
        if_hit_s      = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
        pred_taken_o  = if_hit_s && bht_q[if_idx_s][1];
        if (pred_taken_o) begin
            pred_target_o = target_q[if_idx_s];
        end else begin
            pred_target_o = pc_plus4(if_pc_i);
        end
    end

    // Resolution: a non-branch predicted taken is also a redirect
    always_comb begin
        is_br_s      = ex_valid_i && (ex_br_type_i != NOBRANCH);
        mispredict_o = (is_br_s && ((ex_br_i != ex_pred_taken_i) ||
                                    (ex_br_i && (ex_pred_target_i != ex_target_i))))
                    || (ex_valid_i && !is_br_s && ex_pred_taken_i);
        if (is_br_s && ex_br_i) begin
            redirect_pc_o = ex_target_i;
        end else begin
            redirect_pc_o = pc_plus4(ex_pc_i);
        end
    end

    // Training decisions for the resolving branch
    always_comb begin
        ex_hit_s    = valid_q[ex_idx_s] && (tag_q[ex_idx_s] == ex_tag_s);
        upd_hit_s   = is_br_s && ex_hit_s;
        alloc_s     = is_br_s && !ex_hit_s && ex_br_i;
        wr_target_s = is_br_s && ex_br_i;
    end

    bp_sat_counter2 u_sat (
        .cnt_i (bht_q[ex_idx_s]),
        .inc_i (ex_br_i),
        .cnt_o (bht_next_s)
    );

    // Valid bits and counters: async reset, trained on resolved branches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                bht_q[i]   <= BHT_INIT;
            end
        end else if (upd_hit_s) begin
            bht_q[ex_idx_s] <= bht_next_s;
        end else if (alloc_s) begin
            valid_q[ex_idx_s] <= 1'b1;
            bht_q[ex_idx_s]   <= BHT_ALLOC;
        end else begin
            bht_q[ex_idx_s] <= bht_q[ex_idx_s];
        end
    end

    // Tag and target storage is unreset; valid gates its use
    always_ff @(posedge clk) begin
        if (rst_n && wr_target_s) begin
            target_q[ex_idx_s] <= ex_target_i;
            if (alloc_s) begin
                tag_q[ex_idx_s] <= ex_tag_s;
            end else begin
                tag_q[ex_idx_s] <= tag_q[ex_idx_s];
            end
        end else begin
            target_q[ex_idx_s] <= target_q[ex_idx_s];
        end
    end

    // Statistics next-state, wrapping modulo 2^32
    always_comb begin
        stat_total_d = stat_total_q;
        stat_miss_d  = stat_miss_q;
        if (is_br_s) begin
            stat_total_d = stat_total_q + 32'd1;
            if (mispredict_o) begin
                stat_miss_d = stat_miss_q + 32'd1;
            end else begin
                stat_miss_d = stat_miss_q;
            end
        end else begin
            stat_total_d = stat_total_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total_q <= 32'd0;
            stat_miss_q  <= 32'd0;
        end else begin
            stat_total_q <= stat_total_d;
            stat_miss_q  <= stat_miss_d;
        end
    end

    assign stat_total_o = stat_total_q;
    assign stat_miss_o  = stat_miss_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
import branch_predictor_pkg::*;

module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [2:0]  ex_br_type;
    logic        ex_br;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_total;
    logic [31:0] stat_miss;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc_i          (if_pc),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .ex_valid_i       (ex_valid),
        .ex_pc_i          (ex_pc),
        .ex_br_type_i     (ex_br_type),
        .ex_br_i          (ex_br),
        .ex_target_i      (ex_target),
        .ex_pred_taken_i  (ex_pred_taken),
        .ex_pred_target_i (ex_pred_target),
        .mispredict_o     (mispredict),
        .redirect_pc_o    (redirect_pc),
        .stat_total_o     (stat_total),
        .stat_miss_o      (stat_miss)
    );

    task automatic drive_br(input logic [31:0] pc, input logic [2:0] ty, input logic br,
                            input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_br_type     = ty;
        ex_br          = br;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    task automatic idle();
        ex_valid      = 1'b0;
        ex_br_type    = NOBRANCH;
        ex_br         = 1'b0;
        ex_pred_taken = 1'b0;
    endtask

    // Advance one edge; inputs change and samples happen 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_pc = 32'h100;
        ex_pc = 32'h0; ex_target = 32'h0; ex_pred_target = 32'h0;
        idle();
        #2;
        n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_in_pred_taken: got %b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h104) begin n_fail++; $display("FAIL rst_in_pred_target: got %h want 00000104", pred_target); end
        step(); step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_pred_taken: got %b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'h104) begin n_fail++; $display("FAIL rst_pred_target: got %h want 00000104", pred_target); end
        n_cmp++; if (stat_total !== 32'd0 || stat_miss !== 32'd0) begin n_fail++; $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_total, stat_miss); end
    endtask

    task automatic test_cold_taken();
        drive_br(32'h100, BR_BEQ, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        n_cmp++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL cold_mispredict: got %b want 1", mispredict); end
        n_cmp++; if (redirect_pc !== 32'h80) begin n_fail++; $display("FAIL cold_redirect: got %h want 00000080", redirect_pc); end
        step();
        idle();
        #1;
        n_cmp++; if (stat_miss !== 32'd1 || stat_total !== 32'd1) begin n_fail++; $display("FAIL cold_stats: got %0d/%0d want 1/1", stat_total, stat_miss); end
        n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL cold_pred_taken: got %b want 1", pred_taken); end
        n_cmp++; if (pred_target !== 32'h80) begin n_fail++; $display("FAIL cold_pred_target: got %h want 00000080", pred_target); end
    endtask

    task automatic test_loop_training();
        for (int i = 0; i < 3; i++) begin
            drive_br(32'h100, BR_BEQ, 1'b1, 32'h80, 1'b1, 32'h80);
            #1;
            n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL loop_taken_mp[%0d]: got %b want 0", i, mispredict); end
            step();
        end
        drive_br(32'h100, BR_BEQ, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        n_cmp++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL loop_exit_mp: got %b want 1", mispredict); end
        n_cmp++; if (redirect_pc !== 32'h104) begin n_fail++; $display("FAIL loop_exit_redirect: got %h want 00000104", redirect_pc); end
        step();
        idle();
        #1;
        n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL loop_weak_taken: got %b want 1", pred_taken); end
        n_cmp++; if (stat_total !== 32'd5 || stat_miss !== 32'd2) begin n_fail++; $display("FAIL loop_stats: got %0d/%0d want 5/2", stat_total, stat_miss); end
    endtask

    task automatic test_saturation_floor();
        logic [3:0] exp_pt;
        exp_pt = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            drive_br(32'h100, BR_BEQ, 1'b0, 32'h80, exp_pt[i], exp_pt[i] ? 32'h80 : 32'h104);
            #1;
            n_cmp++; if (pred_taken !== exp_pt[i]) begin n_fail++; $display("FAIL floor_pred[%0d]: got %b want %b", i, pred_taken, exp_pt[i]); end
            n_cmp++; if (mispredict !== exp_pt[i]) begin n_fail++; $display("FAIL floor_mp[%0d]: got %b want %b", i, mispredict, exp_pt[i]); end
            step();
        end
        drive_br(32'h100, BR_BEQ, 1'b1, 32'h80, 1'b0, 32'h104);
        step();
        idle();
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL floor_no_wrap: got %b want 0", pred_taken); end
        n_cmp++; if (stat_total !== 32'd10 || stat_miss !== 32'd4) begin n_fail++; $display("FAIL floor_stats: got %0d/%0d want 10/4", stat_total, stat_miss); end
    endtask

    task automatic test_aliasing();
        drive_br(32'h200, BR_BNE, 1'b1, 32'h40, 1'b0, 32'h204);
        #1;
        n_cmp++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL alias_mp: got %b want 1", mispredict); end
        step();
        idle();
        if_pc = 32'h100;
        #1;
        n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin n_fail++; $display("FAIL alias_evicted: got %b/%h want 0/00000104", pred_taken, pred_target); end
        if_pc = 32'h200;
        #1;
        n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h40) begin n_fail++; $display("FAIL alias_new: got %b/%h want 1/00000040", pred_taken, pred_target); end
        n_cmp++; if (stat_total !== 32'd11 || stat_miss !== 32'd5) begin n_fail++; $display("FAIL alias_stats: got %0d/%0d want 11/5", stat_total, stat_miss); end
    endtask

    task automatic test_non_branch();
        drive_br(32'h200, NOBRANCH, 1'b0, 32'h0, 1'b1, 32'h40);
        #1;
        n_cmp++; if (mispredict !== 1'b1 || redirect_pc !== 32'h204) begin n_fail++; $display("FAIL nobr_defensive: got %b/%h want 1/00000204", mispredict, redirect_pc); end
        ex_pred_taken = 1'b0;
        #1;
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL nobr_quiet: got %b want 0", mispredict); end
        step();
        drive_br(32'h300, BR_BEQ, 1'b1, 32'h10, 1'b0, 32'h304);
        ex_valid = 1'b0;
        #1;
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL bubble_mp: got %b want 0", mispredict); end
        step();
        idle();
        if_pc = 32'h300;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL bubble_no_alloc: got %b want 0", pred_taken); end
        if_pc = 32'h200;
        #1;
        n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h40) begin n_fail++; $display("FAIL nobr_no_train: got %b/%h want 1/00000040", pred_taken, pred_target); end
        n_cmp++; if (stat_total !== 32'd11 || stat_miss !== 32'd5) begin n_fail++; $display("FAIL nobr_stats: got %0d/%0d want 11/5", stat_total, stat_miss); end
    endtask

    task automatic test_same_cycle();
        if_pc = 32'h200;
        drive_br(32'h200, BR_BNE, 1'b0, 32'h40, 1'b1, 32'h40);
        #1;
        n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL same_pre_update: got %b want 1", pred_taken); end
        n_cmp++; if (mispredict !== 1'b1 || redirect_pc !== 32'h204) begin n_fail++; $display("FAIL same_mp: got %b/%h want 1/00000204", mispredict, redirect_pc); end
        step();
        idle();
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL same_post_update: got %b want 0", pred_taken); end
    endtask

    task automatic test_back_to_back();
        if_pc = 32'h200;
        drive_br(32'h200, BR_BNE, 1'b1, 32'h60, 1'b0, 32'h204);
        step();
        drive_br(32'h200, BR_BNE, 1'b1, 32'h60, 1'b1, 32'h60);
        #1;
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL b2b_hit_mp: got %b want 0", mispredict); end
        n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h60) begin n_fail++; $display("FAIL b2b_retarget: got %b/%h want 1/00000060", pred_taken, pred_target); end
        step();
        drive_br(32'h200, BR_BNE, 1'b1, 32'h70, 1'b1, 32'h60);
        #1;
        n_cmp++; if (mispredict !== 1'b1 || redirect_pc !== 32'h70) begin n_fail++; $display("FAIL b2b_wrong_target: got %b/%h want 1/00000070", mispredict, redirect_pc); end
        step();
        idle();
        #1;
        n_cmp++; if (pred_target !== 32'h70) begin n_fail++; $display("FAIL b2b_target_update: got %h want 00000070", pred_target); end
        n_cmp++; if (stat_total !== 32'd15 || stat_miss !== 32'd8) begin n_fail++; $display("FAIL b2b_stats: got %0d/%0d want 15/8", stat_total, stat_miss); end
    endtask

    task automatic test_async_reset();
        if_pc = 32'h200;
        drive_br(32'h104, BR_BLT, 1'b1, 32'h20, 1'b0, 32'h108);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (stat_total !== 32'd0 || stat_miss !== 32'd0) begin n_fail++; $display("FAIL arst_stats: got %0d/%0d want 0/0", stat_total, stat_miss); end
        n_cmp++; if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin n_fail++; $display("FAIL arst_valid_clear: got %b/%h want 0/00000204", pred_taken, pred_target); end
        step();
        idle();
        #2;
        rst_n = 1'b1;
        if_pc = 32'h104;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL arst_no_write: got %b want 0", pred_taken); end
        step();
        n_cmp++; if (stat_total !== 32'd0 || stat_miss !== 32'd0) begin n_fail++; $display("FAIL arst_stats_after: got %0d/%0d want 0/0", stat_total, stat_miss); end
    endtask

    initial begin
        test_reset();
        test_cold_taken();
        test_loop_training();
        test_saturation_floor();
        test_aliasing();
        test_non_branch();
        test_same_cycle();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
